piso_serializer: RTL

Parallel-in/serial-out framing stage that feeds the serial data input of the lab shift-register chain. Accepts a WIDTH-bit word over a valid/ready handshake and emits one framed serial bit per clock: a start bit, then the data bits. The output drives the downstream serial shift register directly, one bit per rising edge.

---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_serializer_if.sv | 31 +++
 rtl/piso_bit_counter.sv | 43 ++++
 rtl/piso_serializer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out framing stage.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

  // Bits needed to count 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the framing stage.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Modulo-MODULUS bit counter with synchronous clear, enable and terminal-count flags.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int MODULUS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic pre_tc
);

  localparam int            CW   = cnt_width(MODULUS);
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);
  localparam logic [CW-1:0] PREV = CW'(MODULUS - 2);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc     = (cnt_reg == LAST);
  // One cycle early so the registered done lands on the last data bit.
  assign pre_tc = (cnt_reg == PREV);

endmodule

// File: rtl/piso_serializer.sv
// Framing serializer: one start bit then WIDTH data bits, one bit per clock,
// with back-to-back frames accepted on the last data bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  piso_serializer_if.slave    bus
);

  localparam int OUT_BIT = LSB_FIRST ? 0 : WIDTH - 1;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shreg_shifted;
  logic             sout_reg;
  logic             sout_next;
  logic             busy_reg;
  logic             busy_next;
  logic             done_reg;
  logic             done_next;
  logic             load_ready;
  logic             accept;
  logic             cnt_tc;
  logic             cnt_pre_tc;

  assign load_ready = (state_reg == IDLE) || ((state_reg == SHIFT) && cnt_tc);
  assign accept     = bus.load_valid && load_ready;

  // The register moves toward OUT_BIT so the next bit to send always sits there.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (LSB_FIRST) begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end
    end
  endgenerate

  piso_bit_counter #(
    .MODULUS (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (state_reg == SHIFT),
    .tc     (cnt_tc),
    .pre_tc (cnt_pre_tc)
  );

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    sout_next  = IDLE_LEVEL;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shreg_next = bus.din;
        end
      end
      START: begin
        state_next = SHIFT;
        shreg_next = shreg_shifted;
        sout_next  = shreg_reg[OUT_BIT];
        busy_next  = 1'b1;
      end
      SHIFT: begin
        if (cnt_tc) begin
          if (accept) begin
            state_next = START;
            shreg_next = bus.din;
          end else begin
            state_next = IDLE;
          end
        end else begin
          shreg_next = shreg_shifted;
          sout_next  = shreg_reg[OUT_BIT];
          busy_next  = 1'b1;
          done_next  = cnt_pre_tc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next == START) begin
      sout_next = START_LEVEL;
      busy_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      sout_reg  <= IDLE_LEVEL;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      sout_reg  <= sout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.sout       = sout_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;

endmodule
